control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have no parameters; widths and encodings are fixed by this document.
REQ-002 SHALL have port: clk  input  1  system clock; t-state advances on falling edge.
REQ-003 SHALL have port: clr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: opcode  input  4  upper nibble from instruction register, valid from T4 onward.
REQ-005 SHALL have port: ctrl  output  14  control word.
- Bit 13 HLT: active-high.
- Bit 12 CP (PC increment): active-high.
- Bit 11 EP (PC out): active-low.
- Bit 10 LM (MAR load): active-low.
- Bit 9 CE (RAM out): active-low.
- Bit 8 LI (IR load): active-low.
- Bit 7 EI (IR out): active-low.
- Bit 6 LA (A load): active-low.
- Bit 5 EA (A out): active-low.
- Bit 4 SU (subtract): active-high.
- Bit 3 EU (ALU out): active-low.
- Bit 2 LB (B load): active-low.
- Bit 1 LO (output reg load): active-low.
- Bit 0 J (PC load): active-low.
REQ-006 SHALL have port: t_state  output  6  one-hot ring state, bit0=T1 ... bit5=T6.

Function
REQ-007 SHALL hold a 6-state one-hot ring counter T1->T2->...->T6->T1, advancing on each falling clk edge.
REQ-008 SHALL decode ctrl combinationally from t_state and opcode; idle word (all signals inactive) = 14'h0FEF.
REQ-009 SHALL drive fetch words for every opcode:
- T1 = 14'h03EF (EP, LM).
- T2 = 14'h1FEF (CP).
- T3 = 14'h0CEF (CE, LI).
REQ-010 SHALL decode LDA (0000):
- T4 = 14'h0B6F (EI, LM).
- T5 = 14'h0DAF (CE, LA).
- T6 = idle.
REQ-011 SHALL decode ADD (0001):
- T4 = 14'h0B6F.
- T5 = 14'h0DEB (CE, LB).
- T6 = 14'h0FA7 (EU, LA).
REQ-012 SHALL decode SUB (0010) as ADD except T6 = 14'h0FB7 (EU, LA, SU); SU is asserted in T6 only.
REQ-013 SHALL decode JMP (0011): T4 = 14'h0F6E (EI, J); T5 and T6 idle.
REQ-014 SHALL decode OUT (1110): T4 = 14'h0FCD (EA, LO); T5 and T6 idle.
REQ-015 SHALL decode HLT (1111):
- On entering T4, set an internal halted flag.
- Freeze the ring at T4.
- Drive ctrl = 14'h2FEF continuously until reset.
REQ-016 SHALL treat all other opcodes as NOP: T4-T6 idle, then return to T1.
REQ-017 SHALL ignore opcode during T1-T3; opcode changes there SHALL NOT alter ctrl.
REQ-018 SHALL NOT assert more than one bus driver (EP, CE, EI, EA, EU) in any state.
REQ-019 SHALL ensure the state (and hence ctrl) never changes on a rising clk edge, so downstream registers sample stable ctrl on rising edges.

Reset
REQ-020 SHALL, while clr=0:
- Force t_state = 6'b000001.
- Clear halted.
- Force ctrl = 14'h0FEF (idle), independent of clk.
REQ-021 SHALL, on clr deassertion, present the T1 word (14'h03EF) immediately and advance to T2 on the first subsequent falling edge.
REQ-022 SHALL abort any instruction on a mid-cycle reset with no partial control pulse after clr falls; HLT is exited only by reset.

Verification
REQ-023 Bench SHALL cover: clr=0 for 12 ns -> t_state=000001, ctrl=0FEF; release -> ctrl=03EF, then 1FEF, 0CEF on successive falling edges.
REQ-024 Bench SHALL cover: opcode=0001 then 0010 -> T4/T5/T6 = 0B6F/0DEB/0FA7, then 0B6F/0DEB/0FB7; SU high only in SUB T6.
REQ-025 Bench SHALL cover: opcode=0000 -> T4/T5/T6 = 0B6F/0DAF/0FEF; opcode=0011 -> T4 = 0F6E; opcode=1110 -> T4 = 0FCD; opcode=0101 -> T4-T6 = 0FEF; ring returns to T1 after T6.
REQ-026 Bench SHALL cover: opcode=1111 -> at T4 ctrl=2FEF, t_state held at 001000 for 20+ cycles; then clr=0 -> ctrl=0FEF, t_state=000001.
REQ-027 Bench SHALL cover: clr pulsed low during ADD T5 -> ctrl=0FEF within the same cycle, no LB pulse; restart from T1.
REQ-028 Bench SHALL cover: opcode toggled during T1-T3 -> ctrl matches fetch words exactly; one-hot check (exactly one t_state bit set) asserted every cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
// Microprogrammed-style control unit for a SAP-1 class CPU. A six-state
// one-hot ring (T1..T6) advances on every falling clock edge and the control
// word is decoded combinationally from the ring state and the opcode nibble.
// Because the ring only moves on falling edges, ctrl is stable around every
// rising edge where the datapath registers sample it.
//
// Ports
//   clk      : system clock, ring advances on the falling edge
//   clr      : asynchronous active-low reset
//   opcode   : upper nibble of the instruction register, used from T4 on
//   ctrl     : 14-bit control word
//              13 HLT(H) 12 CP(H) 11 EP(L) 10 LM(L) 9 CE(L) 8 LI(L) 7 EI(L)
//              6 LA(L) 5 EA(L) 4 SU(H) 3 EU(L) 2 LB(L) 1 LO(L) 0 J(L)
//   t_state  : one-hot ring state, bit0 = T1 ... bit5 = T6
module control_sequencer (
   input  logic        clk,
   input  logic        clr,
   input  logic [3:0]  opcode,
   output logic [13:0] ctrl,
   output logic [5:0]  t_state
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } tstate_e;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_JMP = 4'b0011;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [13:0] W_IDLE    = 14'h0FEF;
   localparam logic [13:0] W_FETCH1  = 14'h03EF;
   localparam logic [13:0] W_FETCH2  = 14'h1FEF;
   localparam logic [13:0] W_FETCH3  = 14'h0CEF;
   localparam logic [13:0] W_IR_MAR  = 14'h0B6F;
   localparam logic [13:0] W_RAM_A   = 14'h0DAF;
   localparam logic [13:0] W_RAM_B   = 14'h0DEB;
   localparam logic [13:0] W_ALU_A   = 14'h0FA7;
   localparam logic [13:0] W_ALU_SUB = 14'h0FB7;
   localparam logic [13:0] W_JUMP    = 14'h0F6E;
   localparam logic [13:0] W_OUT     = 14'h0FCD;
   localparam logic [13:0] W_HALT    = 14'h2FEF;

   tstate_e state;
   tstate_e next_state;
   logic    halted;
   logic    halt_next;

   // Ring register and halt flag. Both move only on falling clk edges so the
   // control word never changes near the rising edge the datapath uses.
   always_ff @(negedge clk or negedge clr) begin
      if (!clr) begin
         state  <= T1;
         halted <= 1'b0;
      end else begin
         state  <= next_state;
         halted <= halt_next;
      end
   end

   // Next-state and control-word decode. Fetch words ignore opcode entirely;
   // execute words depend on it. HLT freezes the ring at T4 and keeps the
   // halt word up until reset. The final clr gate makes ctrl idle the moment
   // reset is asserted, independent of the clock, so an aborted instruction
   // cannot leave a partial load strobe behind.
   always_comb begin
      next_state = state;
      halt_next  = halted;
      ctrl       = W_IDLE;

      if (halted) begin
         ctrl       = W_HALT;
         next_state = state;
      end else begin
         unique case (state)
            T1: begin
               ctrl       = W_FETCH1;
               next_state = T2;
            end
            T2: begin
               ctrl       = W_FETCH2;
               next_state = T3;
            end
            T3: begin
               ctrl       = W_FETCH3;
               next_state = T4;
            end
            T4: begin
               next_state = T5;
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB: ctrl = W_IR_MAR;
                  OP_JMP:                 ctrl = W_JUMP;
                  OP_OUT:                 ctrl = W_OUT;
                  OP_HLT: begin
                     ctrl       = W_HALT;
                     halt_next  = 1'b1;
                     next_state = T4;
                  end
                  default:                ctrl = W_IDLE;
               endcase
            end
            T5: begin
               next_state = T6;
               case (opcode)
                  OP_LDA:         ctrl = W_RAM_A;
                  OP_ADD, OP_SUB: ctrl = W_RAM_B;
                  default:        ctrl = W_IDLE;
               endcase
            end
            T6: begin
               next_state = T1;
               case (opcode)
                  OP_ADD:  ctrl = W_ALU_A;
                  OP_SUB:  ctrl = W_ALU_SUB;
                  default: ctrl = W_IDLE;
               endcase
            end
            default: begin
               ctrl       = W_IDLE;
               next_state = T1;
            end
         endcase
      end

      if (!clr) begin
         ctrl = W_IDLE;
      end
   end

   assign t_state = state;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
// Scoreboard bench for control_sequencer. Stimulus tasks drive clr/opcode just
// after each falling edge and push the hand-computed {ctrl, t_state} expected
// for that cycle. A separate monitor pops and compares on every rising edge
// (mid-cycle, when ctrl is stable) and on explicit mid-cycle sample events,
// and checks the ring is one-hot on every sample.
module tb_control_sequencer;

   logic        clk;
   logic        clr;
   logic [3:0]  opcode;
   logic [13:0] ctrl;
   logic [5:0]  t_state;

   logic [19:0] expQ[$];
   string       nameQ[$];
   int          compared;
   int          mismatched;
   event        midEv;

   control_sequencer dut (
      .clk     (clk),
      .clr     (clr),
      .opcode  (opcode),
      .ctrl    (ctrl),
      .t_state (t_state)
   );

   // Free-running clock, 10 ns period, falling edges at 5, 15, 25 ...
   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   // Monitor: compare the oldest expectation against the DUT and check the
   // ring is one-hot at every sample point.
   initial begin
      logic [19:0] e;
      string       n;
      compared   = 0;
      mismatched = 0;
      forever begin
         @(posedge clk or midEv);
         compared++;
         if ($countones(t_state) != 1) begin
            mismatched++;
            $display("[TB] FAIL onehot: t_state=%b is not one-hot", t_state);
         end
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            compared++;
            if (ctrl !== e[19:6]) begin
               mismatched++;
               $display("[TB] FAIL %s ctrl: got %h expected %h", n, ctrl, e[19:6]);
            end
            compared++;
            if (t_state !== e[5:0]) begin
               mismatched++;
               $display("[TB] FAIL %s t_state: got %b expected %b", n, t_state, e[5:0]);
            end
         end
      end
   end

   // One clock cycle of stimulus plus the expected response for that cycle.
   task automatic applyStimulus(input logic clrVal, input logic [3:0] op,
                                input logic [13:0] expCtrl, input logic [5:0] expT,
                                input string name);
      @(negedge clk);
      #1;
      clr    = clrVal;
      opcode = op;
      expQ.push_back({expCtrl, expT});
      nameQ.push_back(name);
   endtask

   // Pull clr low in the middle of the current cycle and sample immediately.
   task automatic midReset(input string name);
      @(posedge clk);
      #2;
      clr = 1'b0;
      #1;
      expQ.push_back({14'h0FEF, 6'b000001});
      nameQ.push_back(name);
      -> midEv;
   endtask

   // Fetch cycles, with a scrambled opcode so fetch decode must ignore it.
   task automatic runFetch(input logic [3:0] op);
      applyStimulus(1'b1, op ^ 4'hA, 14'h03EF, 6'b000001, "T1");
      applyStimulus(1'b1, op ^ 4'h5, 14'h1FEF, 6'b000010, "T2");
      applyStimulus(1'b1, ~op,       14'h0CEF, 6'b000100, "T3");
   endtask

   // A full six-state instruction with hand-computed execute words.
   task automatic runInstr(input logic [3:0] op, input logic [13:0] e4,
                           input logic [13:0] e5, input logic [13:0] e6,
                           input string name);
      runFetch(op);
      applyStimulus(1'b1, op, e4, 6'b001000, {name, "_T4"});
      applyStimulus(1'b1, op, e5, 6'b010000, {name, "_T5"});
      applyStimulus(1'b1, op, e6, 6'b100000, {name, "_T6"});
   endtask

   // Directed test sequence.
   initial begin
      clr    = 1'b0;
      opcode = 4'h0;

      applyStimulus(1'b0, 4'h3, 14'h0FEF, 6'b000001, "reset0");
      applyStimulus(1'b0, 4'hF, 14'h0FEF, 6'b000001, "reset1");

      runInstr(4'b0001, 14'h0B6F, 14'h0DEB, 14'h0FA7, "ADD");
      runInstr(4'b0010, 14'h0B6F, 14'h0DEB, 14'h0FB7, "SUB");
      runInstr(4'b0000, 14'h0B6F, 14'h0DAF, 14'h0FEF, "LDA");
      runInstr(4'b0011, 14'h0F6E, 14'h0FEF, 14'h0FEF, "JMP");
      runInstr(4'b1110, 14'h0FCD, 14'h0FEF, 14'h0FEF, "OUT");
      runInstr(4'b0101, 14'h0FEF, 14'h0FEF, 14'h0FEF, "NOP");

      // ADD aborted by a reset pulse in the middle of T5.
      runFetch(4'b0001);
      applyStimulus(1'b1, 4'b0001, 14'h0B6F, 6'b001000, "ABRT_T4");
      applyStimulus(1'b1, 4'b0001, 14'h0DEB, 6'b010000, "ABRT_T5");
      midReset("ABRT_mid");
      applyStimulus(1'b0, 4'b0001, 14'h0FEF, 6'b000001, "ABRT_held");
      runInstr(4'b0001, 14'h0B6F, 14'h0DEB, 14'h0FA7, "ADD2");

      // HLT freezes at T4 regardless of later opcode changes.
      runFetch(4'b1111);
      applyStimulus(1'b1, 4'b1111, 14'h2FEF, 6'b001000, "HLT_T4");
      for (int i = 0; i < 22; i++) begin
         applyStimulus(1'b1, (i < 11) ? 4'b1111 : 4'(i), 14'h2FEF, 6'b001000, "HLT_hold");
      end
      midReset("HLT_rst");
      applyStimulus(1'b0, 4'b1111, 14'h0FEF, 6'b000001, "HLT_held");
      runInstr(4'b0010, 14'h0B6F, 14'h0DEB, 14'h0FB7, "SUB2");
      applyStimulus(1'b1, 4'b0000, 14'h03EF, 6'b000001, "wrap_T1");

      @(negedge clk);
      @(negedge clk);
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
